// File: rtl/div_sequencer.sv
// Sequencer for the shared 32-step restoring divider used by DIV/DIVU: operand magnitudes,
// step-enable timing, sign fix-up into HI/LO and a divide-by-zero pulse. DIVSEQ_SIGNED_EN enables DIV.
module div_sequencer #(
  parameter int STEPS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dv_op,
  output logic [31:0] dv_dividend,
  output logic [31:0] dv_divisor,
  input  logic [31:0] dv_hi,
  input  logic [31:0] dv_lo,
  output logic [1:0]  state_dbg
);

  // Handshake: start is a one-cycle request with no ready; it is taken only while busy is low,
  // and a start seen while busy is dropped, not queued.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          div0_q, div0_d;
  logic          dv_op_q, dv_op_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   dvd_q, dvd_d;
  logic [31:0]   dvs_q, dvs_d;
  logic [31:0]   a_mag, b_mag;
  logic [31:0]   quo_fix, rem_fix;

`ifdef DIVSEQ_SIGNED_EN
  logic sgn_quo_q, sgn_quo_d;
  logic sgn_rem_q, sgn_rem_d;

  function automatic logic [31:0] mag(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  assign a_mag   = is_signed ? mag(op_a) : op_a;
  assign b_mag   = is_signed ? mag(op_b) : op_b;
  assign quo_fix = sgn_quo_q ? (~dv_lo + 32'd1) : dv_lo;
  assign rem_fix = sgn_rem_q ? (~dv_hi + 32'd1) : dv_hi;
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign a_mag   = op_a;
  assign b_mag   = op_b;
  assign quo_fix = dv_lo;
  assign rem_fix = dv_hi;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    div0_d  = 1'b0;
    dv_op_d = dv_op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
`ifdef DIVSEQ_SIGNED_EN
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (op_b == '0) begin
            state_d = ERR;
            div0_d  = 1'b1;
          end else begin
            state_d = RUN;
            dv_op_d = 1'b1;
            cnt_d   = '0;
            dvd_d   = a_mag;
            dvs_d   = b_mag;
`ifdef DIVSEQ_SIGNED_EN
            sgn_quo_d = is_signed & (op_a[31] ^ op_b[31]);
            sgn_rem_d = is_signed & op_a[31];
`endif
          end
        end
      end
      RUN: begin
        // dv_op was raised at the accepting edge, so leaving on count STEPS-1 gives STEPS steps.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = FIX;
          dv_op_d = 1'b0;
        end
      end
      FIX: begin
        lo_d    = quo_fix;
        hi_d    = rem_fix;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      ERR: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        dv_op_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      dv_op_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
`ifdef DIVSEQ_SIGNED_EN
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
      dv_op_q <= dv_op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
`ifdef DIVSEQ_SIGNED_EN
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div0        = div0_q;
  assign dv_op       = dv_op_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dv_dividend = dvd_q;
  assign dv_divisor  = dvs_q;
  assign state_dbg   = state_q;

endmodule
